alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Parametrised ALU execution stage: decodes ALUOp/funct3/funct7 internally, computes result, returns it over a valid/ready handshake.
- Successor to the combinational ALU control decode. Adds WIDTH generalisation, SLTU/SRA, illegal-op flagging, registered output with backpressure, and an optional iterative multiplier.
- Sits between register-read and writeback in the multi-cycle core.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8, power of 2).
- SHAMT_W, $clog2(WIDTH), shift-amount bits taken from op_b.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept request.
- alu_op  in  2  00 load/store add, 01 branch sub, 10 R-type, 11 I-type.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7 (I-type uses only bit 5, for SRAI).
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B or immediate.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  computed result.
- zero  out  1  result == 0 (branch use).
- illegal  out  1  decode rejected the request; result forced to 0.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, result=0, zero=0, illegal=0, FSM=IDLE. in_ready=1 once reset is released.
- Accept: a request is accepted at a rising edge where in_valid && in_ready.
- Decode, alu_op=00: ADD.
- Decode, alu_op=01: SUB.
- Decode, alu_op=10, funct7=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- Decode, alu_op=10, funct7=0100000: funct3 000 SUB, 101 SRA. Any other funct3 is illegal.
- Decode, alu_op=10, funct7=0000001: MUL when ALU_MUL_EN is defined, illegal otherwise.
- Decode, alu_op=10, any other funct7: illegal.
- Decode, alu_op=11: funct3 as R-type but with no SUB. funct3=101 with funct7[5]=1 gives SRAI. funct3=001 with funct7[5]=1 is illegal.
- Arithmetic: mod 2^WIDTH, carries discarded. SLT is signed, SLTU unsigned, both giving 0 or 1 zero-extended. Shifts use op_b[SHAMT_W-1:0]. SRA replicates the MSB.
- Single-cycle ops and illegal requests:
  - Result registered; out_valid rises the cycle after accept (latency 1).
  - Illegal gives illegal=1, result=0, zero=1.
- Output hold: result, zero and illegal stay stable while out_valid && !out_ready. out_valid clears on the handshake edge unless a new request is accepted in the same edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Back-to-back throughput is 1 op per cycle.
- FSM states: IDLE, MUL (present only with ALU_MUL_EN).
  - IDLE -> MUL when a MUL is accepted.
  - MUL -> IDLE after WIDTH iterations. Result then loads and out_valid=1. Accept-to-out_valid latency is WIDTH+1 cycles.
  - in_ready=0 throughout MUL.
- Reset mid-MUL: iteration aborts; the FSM returns to IDLE and no result is produced.
- Inputs are ignored when in_valid=0; no state change.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: funct7=0000001 with alu_op=10 performs an unsigned shift-add multiply, low WIDTH bits only, taking WIDTH cycles.
- Undefined: the MUL state and multiplier logic are absent, and that encoding is flagged illegal with latency 1.

Decomposition:
- Package alu_pkg: alu_op_e (ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, MUL, ILL) and ALUOP_* constants (00/01/10/11).
- FUNCT7_BASE, FUNCT7_ALT and FUNCT7_MULDIV are also in alu_pkg.
- One sub-module, alu_mul_iter: start/busy/done ports, WIDTH parameter, operands latched on start.

Test Plan:
- WIDTH=32: alu_op=10, f3=000, f7=0100000, a=5, b=7 -> next cycle out_valid=1, result=0xFFFFFFFE, zero=0, illegal=0.
- alu_op=11, f3=101, f7[5]=1, a=0x80000000, b=4 -> result=0xF8000000; same with f7[5]=0 -> 0x08000000.
- SLT vs SLTU with a=0xFFFFFFFF, b=1 -> SLT=1, SLTU=0. Then alu_op=10, f3=010, f7=0100000 -> illegal=1, result=0, zero=1.
- Backpressure: out_ready=0 for 3 cycles after result 0x12 -> result held, in_ready=0. Raising out_ready with a new in_valid gives the next result on the following cycle with no bubble.
- ALU_MUL_EN: a=0x10000, b=0x30001 -> in_ready=0 for 32 cycles, out_valid at cycle 33, result=0x00010000 (low 32 bits).
- rst_n=0 at cycle 10 of a MUL -> out_valid=0 immediately; after release in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU execution stage shared types: request opcodes, FSM states, ALUOp/funct encodings and the decoder.
package alu_pkg;

  localparam logic [1:0] ALUOP_LS = 2'b00;
  localparam logic [1:0] ALUOP_BR = 2'b01;
  localparam logic [1:0] ALUOP_R  = 2'b10;
  localparam logic [1:0] ALUOP_I  = 2'b11;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, MUL, ILL
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  function automatic alu_op_e alu_f3_base(input logic [2:0] f3);
    alu_op_e op;
    op = ILL;
    case (f3)
      F3_ADD:  op = ADD;
      F3_SLL:  op = SLL;
      F3_SLT:  op = SLT;
      F3_SLTU: op = SLTU;
      F3_XOR:  op = XOR;
      F3_SR:   op = SRL;
      F3_OR:   op = OR;
      F3_AND:  op = AND;
      default: op = ILL;
    endcase
    return op;
  endfunction

  // I-type only looks at funct7[5]; its upper immediate bits are don't-care.
  function automatic alu_op_e alu_decode(input logic [1:0] alu_op, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic mul_en);
    alu_op_e op;
    op = ILL;
    case (alu_op)
      ALUOP_LS: op = ADD;
      ALUOP_BR: op = SUB;
      ALUOP_R: begin
        if (f7 == FUNCT7_BASE) begin
          op = alu_f3_base(f3);
        end else if (f7 == FUNCT7_ALT) begin
          if (f3 == F3_ADD)     op = SUB;
          else if (f3 == F3_SR) op = SRA;
          else                  op = ILL;
        end else if (f7 == FUNCT7_MULDIV) begin
          op = mul_en ? MUL : ILL;
        end else begin
          op = ILL;
        end
      end
      ALUOP_I: begin
        op = alu_f3_base(f3);
        if (f3 == F3_SR && f7[5])  op = SRA;
        if (f3 == F3_SLL && f7[5]) op = ILL;
      end
      default: op = ILL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier, low WIDTH bits; operands latched on start.
// One partial product per cycle, done pulses for one cycle after WIDTH iterations.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_mcand  <= op_a;
        r_mplier <= op_b;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end else if (r_busy) begin
        r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_acc;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution stage: decodes ALUOp/funct3/funct7, registers result; ALU_MUL_EN adds an iterative MUL.
// Latency 1 for single-cycle and illegal ops, WIDTH+1 for MUL; output held while out_ready is low.
// in_ready drops while a result is stalled or a MUL is iterating; 1 op/cycle when unstalled.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  import alu_pkg::*;

`ifdef ALU_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_illegal;

  logic               w_in_ready;
  logic               w_accept;
  alu_op_e            w_op;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_mul_done;
  logic [WIDTH-1:0]   w_mul_prod;

  assign w_accept = in_valid && w_in_ready;
  assign w_op     = alu_decode(alu_op, funct3, funct7, MUL_EN);
  assign w_shamt  = op_b[SHAMT_W-1:0];

  always_comb begin
    w_alu_res = '0;
    case (w_op)
      ADD:     w_alu_res = op_a + op_b;
      SUB:     w_alu_res = op_a - op_b;
      AND:     w_alu_res = op_a & op_b;
      OR:      w_alu_res = op_a | op_b;
      XOR:     w_alu_res = op_a ^ op_b;
      SLT:     w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      SLTU:    w_alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      SLL:     w_alu_res = op_a << w_shamt;
      SRL:     w_alu_res = op_a >> w_shamt;
      SRA:     w_alu_res = $signed(op_a) >>> w_shamt;
      default: w_alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  alu_state_e r_state;
  alu_state_e w_state_nxt;
  logic       w_mul_start;
  logic       w_mul_busy;

  assign w_mul_start = w_accept && (w_op == MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_mul_start) w_state_nxt = ST_MUL;
      ST_MUL:  if (w_mul_done)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = (r_state == ST_IDLE) && !w_mul_busy && (!r_out_valid || out_ready);
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mul_start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_mul_prod)
  );
`else
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_mul_done = 1'b0;
  assign w_mul_prod = '0;
`endif

  // A MUL accept never loads the output register; it falls through so a pending handshake still clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept && (w_op != MUL)) begin
      r_out_valid <= 1'b1;
      r_result    <= w_alu_res;
      r_zero      <= (w_alu_res == '0);
      r_illegal   <= (w_op == ILL);
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_mul_prod;
      r_zero      <= (w_mul_prod == '0);
      r_illegal   <= 1'b0;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit at WIDTH=32; covers both ALU_MUL_EN builds.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   alu_op;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7    (funct7),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    funct3   = f3;
    funct7   = f7;
    op_a     = a;
    op_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [W-1:0] r, input logic ill);
    check({tag, ".vld"},  out_valid, 1);
    check({tag, ".res"},  result, r);
    check({tag, ".zero"}, zero, (r == '0));
    check({tag, ".ill"},  illegal, ill);
  endtask

  initial begin
    logic saw_valid;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_op    = 2'b00;
    funct3    = 3'b000;
    funct7    = 7'b0;
    op_a      = '0;
    op_b      = '0;
    #1;
    check("rst.vld",  out_valid, 0);
    check("rst.res",  result, 0);
    check("rst.zero", zero, 0);
    check("rst.ill",  illegal, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst.in_ready", in_ready, 1);

    // Single-cycle ops, back to back with out_ready high
    send(ALUOP_R, 3'b000, 7'b0100000, 32'd5, 32'd7);
    expect_res("sub_r", 32'hFFFF_FFFE, 0);
    send(ALUOP_I, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4);
    expect_res("srai", 32'hF800_0000, 0);
    send(ALUOP_I, 3'b101, 7'b0000000, 32'h8000_0000, 32'd4);
    expect_res("srli", 32'h0800_0000, 0);
    send(ALUOP_R, 3'b010, 7'b0000000, 32'hFFFF_FFFF, 32'd1);
    expect_res("slt", 32'd1, 0);
    send(ALUOP_R, 3'b011, 7'b0000000, 32'hFFFF_FFFF, 32'd1);
    expect_res("sltu", 32'd0, 0);
    send(ALUOP_R, 3'b010, 7'b0100000, 32'hFFFF_FFFF, 32'd1);
    expect_res("ill_alt_f3", 32'd0, 1);
    send(ALUOP_LS, 3'b111, 7'b1111111, 32'hFFFF_FFFF, 32'd1);
    expect_res("add_wrap", 32'd0, 0);
    send(ALUOP_BR, 3'b000, 7'b0000000, 32'h10, 32'h3);
    expect_res("br_sub", 32'hD, 0);
    send(ALUOP_R, 3'b111, 7'b0000000, 32'hF0F0, 32'hFF00);
    expect_res("and", 32'hF000, 0);
    send(ALUOP_R, 3'b110, 7'b0000000, 32'hF0F0, 32'h0F00);
    expect_res("or", 32'hFFF0, 0);
    send(ALUOP_R, 3'b001, 7'b0000000, 32'd1, 32'h21);
    expect_res("sll_shamt", 32'd2, 0);
    send(ALUOP_R, 3'b101, 7'b0000000, 32'h8000_0000, 32'd31);
    expect_res("srl31", 32'd1, 0);
    send(ALUOP_R, 3'b101, 7'b0100000, 32'h8000_0000, 32'd31);
    expect_res("sra31", 32'hFFFF_FFFF, 0);
    send(ALUOP_I, 3'b000, 7'b0100000, 32'd5, 32'd3);
    expect_res("addi_f7", 32'd8, 0);
    send(ALUOP_I, 3'b001, 7'b0100000, 32'd5, 32'd3);
    expect_res("ill_slli", 32'd0, 1);
    send(ALUOP_R, 3'b000, 7'b0000010, 32'd5, 32'd3);
    expect_res("ill_f7", 32'd0, 1);
    tick();
    check("idle.vld", out_valid, 0);

    // Backpressure: hold 0x12 for three cycles, then handshake and accept in one edge
    out_ready = 1'b0;
    send(ALUOP_LS, 3'b000, 7'b0, 32'h10, 32'h2);
    expect_res("bp_first", 32'h12, 0);
    for (int i = 0; i < 3; i++) begin
      op_a = 32'hDEAD_BEEF;
      tick();
      check("bp_hold.res",  result, 32'h12);
      check("bp_hold.vld",  out_valid, 1);
      check("bp_hold.rdy",  in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_op    = ALUOP_R;
    funct3    = 3'b100;
    funct7    = 7'b0;
    op_a      = 32'hF0;
    op_b      = 32'h0F;
    #1;
    check("bp_release.rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    expect_res("bp_next", 32'hFF, 0);
    tick();
    check("bp_drain.vld", out_valid, 0);

`ifdef ALU_MUL_EN
    send(ALUOP_R, 3'b000, FUNCT7_MULDIV, 32'h0001_0000, 32'h0003_0001);
    check("mul.rdy0", in_ready, 0);
    check("mul.vld0", out_valid, 0);
    for (int i = 1; i <= W; i++) begin
      tick();
      check("mul.busy_rdy", in_ready, 0);
      check("mul.busy_vld", out_valid, 0);
    end
    tick();
    expect_res("mul", 32'h0001_0000, 0);
    tick();
    check("mul.drain", out_valid, 0);

    send(ALUOP_R, 3'b000, FUNCT7_MULDIV, 32'd3, 32'd5);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("mul_rst.vld", out_valid, 0);
    rst_n = 1'b1;
    tick();
    check("mul_rst.rdy", in_ready, 1);
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      saw_valid = saw_valid | out_valid;
    end
    check("mul_rst.no_stale", saw_valid, 0);
`else
    send(ALUOP_R, 3'b000, FUNCT7_MULDIV, 32'h0001_0000, 32'h0003_0001);
    expect_res("mul_off_ill", 32'd0, 1);
    tick();
    check("mul_off.drain", out_valid, 0);
`endif

    // Asynchronous reset while a stalled result is held
    out_ready = 1'b0;
    send(ALUOP_LS, 3'b000, 7'b0, 32'd1, 32'd1);
    expect_res("pre_arst", 32'd2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.vld", out_valid, 0);
    check("arst.res", result, 0);
    check("arst.ill", illegal, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("arst.rdy", in_ready, 1);
    check("arst.quiet", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
